// File: rtl/rs_issue_select.sv
// -----------------------------------------------------------------------------
// rs_issue_select
//   Issue stage between the reservation stations and the functional units.
//   For every FU class (0=ALU 1=Load 2=Store 3=FloatingPoint) a round-robin
//   picker selects at most one ready RS entry per cycle.  The picked entry's
//   ROB tag and operands are captured into that class's issue register, and a
//   combinational one-hot issue_ack tells the RS which entries were taken.
//   The FP unit is not pipelined, so a countdown keeps a new FP op from
//   landing in the issue register until FP_LAT cycles after the previous
//   FP handshake.
//
// Ports
//   clock       in   1              rising-edge clock
//   reset       in   1              asynchronous, active-low reset
//   squash      in   1              flush: drop every held op, suppress acks
//   rs_ready    in   NUM_RS         entry i is ready to issue
//   rs_fu       in   2*NUM_RS       FU class of entry i, bits [2i+1:2i]
//   rs_rob_tag  in   TAG_W*NUM_RS   ROB tag of entry i
//   rs_v1       in   DATA_W*NUM_RS  operand 1 of entry i
//   rs_v2       in   DATA_W*NUM_RS  operand 2 of entry i
//   issue_ack   out  NUM_RS         combinational; entry i captured this cycle
//   fu_valid    out  NUM_FU         issue register k holds a valid op
//   fu_ready    in   NUM_FU         FU k accepts this cycle
//   fu_rob_tag  out  TAG_W*NUM_FU   ROB tag presented to FU k
//   fu_v1       out  DATA_W*NUM_FU  operand 1 presented to FU k
//   fu_v2       out  DATA_W*NUM_FU  operand 2 presented to FU k
// -----------------------------------------------------------------------------
module rs_issue_select #(
  parameter int NUM_RS = 5,
  parameter int TAG_W  = 3,
  parameter int DATA_W = 32,
  parameter int NUM_FU = 4,
  parameter int FP_LAT = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       squash,
  input  logic [NUM_RS-1:0]          rs_ready,
  input  logic [2*NUM_RS-1:0]        rs_fu,
  input  logic [TAG_W*NUM_RS-1:0]    rs_rob_tag,
  input  logic [DATA_W*NUM_RS-1:0]   rs_v1,
  input  logic [DATA_W*NUM_RS-1:0]   rs_v2,
  output logic [NUM_RS-1:0]          issue_ack,
  output logic [NUM_FU-1:0]          fu_valid,
  input  logic [NUM_FU-1:0]          fu_ready,
  output logic [TAG_W*NUM_FU-1:0]    fu_rob_tag,
  output logic [DATA_W*NUM_FU-1:0]   fu_v1,
  output logic [DATA_W*NUM_FU-1:0]   fu_v2
);

  localparam int IDX_W  = (NUM_RS > 1) ? $clog2(NUM_RS) : 1;
  localparam int CNT_W  = (FP_LAT > 1) ? $clog2(FP_LAT) : 1;
  localparam int FP_IDX = 3;
  localparam logic [CNT_W-1:0] FP_RELOAD = CNT_W'(FP_LAT - 1);

  // Per-entry views of the flattened RS buses (same bit layout, just typed
  // as arrays so entries can be indexed by the picker).
  logic [NUM_RS-1:0][1:0]        ent_fu;
  logic [NUM_RS-1:0][TAG_W-1:0]  ent_tag;
  logic [NUM_RS-1:0][DATA_W-1:0] ent_v1;
  logic [NUM_RS-1:0][DATA_W-1:0] ent_v2;

  assign ent_fu  = rs_fu;
  assign ent_tag = rs_rob_tag;
  assign ent_v1  = rs_v1;
  assign ent_v2  = rs_v2;

  logic [NUM_FU-1:0]             fire;
  logic [NUM_FU-1:0][NUM_RS-1:0] cls_ack;

  assign fire = fu_valid & fu_ready;

  // ---------------------------------------------------------------------------
  // FP occupancy countdown
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] fp_cnt_q;
  logic [CNT_W-1:0] fp_cnt_d;
  logic [CNT_W-1:0] fp_cnt_next;
  logic             fp_free;

  always_comb begin
    if (fire[FP_IDX]) begin
      fp_cnt_next = FP_RELOAD;
    end else if (fp_cnt_q != '0) begin
      fp_cnt_next = fp_cnt_q - CNT_W'(1);
    end else begin
      fp_cnt_next = '0;
    end
    fp_cnt_d = squash ? '0 : fp_cnt_next;
  end

  // Gate on the count the FP unit will have next cycle: an op loaded now shows
  // up next cycle, which is exactly FP_LAT cycles after the previous handshake.
  // With FP_LAT==1 a handshake reloads 0, so back-to-back issue is allowed.
  assign fp_free = (fp_cnt_next == '0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fp_cnt_q <= '0;
    end else begin
      fp_cnt_q <= fp_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-class picker and issue register
  // ---------------------------------------------------------------------------
  for (genvar k = 0; k < NUM_FU; k++) begin : g_cls
    logic              found;
    logic [IDX_W-1:0]  pick;
    logic [IDX_W:0]    cand;
    logic              can_load;
    logic              load;
    logic [IDX_W-1:0]  pick_next;
    logic [NUM_RS-1:0] sel_ack;

    logic              valid_q, valid_d;
    logic [TAG_W-1:0]  tag_q,   tag_d;
    logic [DATA_W-1:0] v1_q,    v1_d;
    logic [DATA_W-1:0] v2_q,    v2_d;
    logic [IDX_W-1:0]  ptr_q,   ptr_d;

    // Round-robin scan starting at ptr_q; the first matching ready entry wins.
    always_comb begin
      found = 1'b0;
      pick  = '0;
      cand  = '0;
      for (int off = 0; off < NUM_RS; off++) begin
        cand = {1'b0, ptr_q} + (IDX_W+1)'(off);
        if (cand >= (IDX_W+1)'(NUM_RS)) begin
          cand = cand - (IDX_W+1)'(NUM_RS);
        end
        if (!found && rs_ready[cand[IDX_W-1:0]] &&
            (ent_fu[cand[IDX_W-1:0]] == 2'(k))) begin
          found = 1'b1;
          pick  = cand[IDX_W-1:0];
        end
      end
    end

    // The register can take a new op when empty or when its current op is
    // leaving this cycle; the FP class also waits out the occupancy count.
    assign can_load  = (!valid_q || fire[k]) && ((k != FP_IDX) || fp_free);
    assign load      = found && can_load && !squash;
    assign pick_next = (pick == IDX_W'(NUM_RS - 1)) ? '0 : pick + IDX_W'(1);

    always_comb begin
      sel_ack = '0;
      if (load) begin
        sel_ack[pick] = 1'b1;
      end
    end

    assign cls_ack[k] = sel_ack;

    always_comb begin
      valid_d = valid_q;
      tag_d   = tag_q;
      v1_d    = v1_q;
      v2_d    = v2_q;
      ptr_d   = ptr_q;
      if (squash) begin
        // Held ops are dropped; the pointer keeps its fairness position.
        valid_d = 1'b0;
      end else if (load) begin
        valid_d = 1'b1;
        tag_d   = ent_tag[pick];
        v1_d    = ent_v1[pick];
        v2_d    = ent_v2[pick];
        ptr_d   = pick_next;
      end else if (fire[k]) begin
        valid_d = 1'b0;
      end
    end

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        valid_q <= 1'b0;
        tag_q   <= '0;
        v1_q    <= '0;
        v2_q    <= '0;
        ptr_q   <= '0;
      end else begin
        valid_q <= valid_d;
        tag_q   <= tag_d;
        v1_q    <= v1_d;
        v2_q    <= v2_d;
        ptr_q   <= ptr_d;
      end
    end

    assign fu_valid[k]                   = valid_q;
    assign fu_rob_tag[k*TAG_W +: TAG_W]  = tag_q;
    assign fu_v1[k*DATA_W +: DATA_W]     = v1_q;
    assign fu_v2[k*DATA_W +: DATA_W]     = v2_q;
  end

  // ---------------------------------------------------------------------------
  // Acknowledge back to the RS
  // ---------------------------------------------------------------------------
  // Each entry belongs to exactly one class, so OR-ing the per-class one-hots
  // never merges two picks onto one bit.  Nothing is acked while in reset.
  always_comb begin
    issue_ack = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      issue_ack = issue_ack | cls_ack[k];
    end
    if (!reset) begin
      issue_ack = '0;
    end
  end

endmodule

// File: tb/tb_rs_issue_select.sv
module tb_rs_issue_select;

  logic         clock = 1'b0;
  logic         reset;
  logic         squash;
  logic [4:0]   rs_ready;
  logic [9:0]   rs_fu;
  logic [14:0]  rs_rob_tag;
  logic [159:0] rs_v1;
  logic [159:0] rs_v2;
  logic [4:0]   issue_ack;
  logic [3:0]   fu_valid;
  logic [3:0]   fu_ready;
  logic [11:0]  fu_rob_tag;
  logic [127:0] fu_v1;
  logic [127:0] fu_v2;

  rs_issue_select dut (
    .clock      (clock),
    .reset      (reset),
    .squash     (squash),
    .rs_ready   (rs_ready),
    .rs_fu      (rs_fu),
    .rs_rob_tag (rs_rob_tag),
    .rs_v1      (rs_v1),
    .rs_v2      (rs_v2),
    .issue_ack  (issue_ack),
    .fu_valid   (fu_valid),
    .fu_ready   (fu_ready),
    .fu_rob_tag (fu_rob_tag),
    .fu_v1      (fu_v1),
    .fu_v2      (fu_v2)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct { int cyc; logic [4:0] vec; } ack_t;
  typedef struct { int cyc; int cls; logic [2:0] tag; logic [31:0] v1; logic [31:0] v2; } fire_t;
  typedef struct {
    int cyc; logic [3:0] vld; logic [4:0] ack; logic [3:0] mask;
    logic [11:0] tag; logic [127:0] v1; logic [127:0] v2;
  } snap_t;

  ack_t  ack_q[$];
  fire_t fire_q[$];
  snap_t snap_q[$];

  int checks = 0;
  int errors = 0;
  logic [4:0] last_ack = '0;
  logic [4:0] prev_ack = '0;
  logic done = 1'b0;
  logic final_done = 1'b0;

  ack_t  a_cur;
  fire_t f_cur;
  snap_t s_cur;
  logic [11:0]  tmask;
  logic [127:0] dmask;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  // Monitor / scoreboard: the only process that compares.
  always @(negedge clock) begin
    last_ack = issue_ack;
    if (snap_q.size() != 0 && snap_q[0].cyc == cyc) begin
      s_cur = snap_q.pop_front();
      tmask = '0;
      dmask = '0;
      for (int k = 0; k < 4; k++) begin
        if (s_cur.mask[k]) begin
          tmask[k*3 +: 3]   = 3'b111;
          dmask[k*32 +: 32] = 32'hFFFF_FFFF;
        end
      end
      chk("snap_fu_valid", 128'(fu_valid), 128'(s_cur.vld));
      chk("snap_issue_ack", 128'(issue_ack), 128'(s_cur.ack));
      chk("snap_fu_rob_tag", 128'(fu_rob_tag & tmask), 128'(s_cur.tag & tmask));
      chk("snap_fu_v1", fu_v1 & dmask, s_cur.v1 & dmask);
      chk("snap_fu_v2", fu_v2 & dmask, s_cur.v2 & dmask);
    end
    if (reset) begin
      if (issue_ack != '0) begin
        if (ack_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL ack_unexpected cyc=%0d got=%b want=none", cyc, issue_ack);
        end else begin
          a_cur = ack_q.pop_front();
          chk("ack_cycle", 128'(cyc), 128'(a_cur.cyc));
          chk("ack_vector", 128'(issue_ack), 128'(a_cur.vec));
        end
        chk("ack_twice", 128'(issue_ack & prev_ack), 128'(0));
      end
      for (int k = 0; k < 4; k++) begin
        if (fu_valid[k] && fu_ready[k]) begin
          if (fire_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL fire_unexpected cyc=%0d got=class%0d want=none", cyc, k);
          end else begin
            f_cur = fire_q.pop_front();
            chk("fire_cycle", 128'(cyc), 128'(f_cur.cyc));
            chk("fire_class", 128'(k), 128'(f_cur.cls));
            chk("fire_tag", 128'(fu_rob_tag[k*3 +: 3]), 128'(f_cur.tag));
            chk("fire_v1", 128'(fu_v1[k*32 +: 32]), 128'(f_cur.v1));
            chk("fire_v2", 128'(fu_v2[k*32 +: 32]), 128'(f_cur.v2));
          end
        end
      end
    end
    prev_ack = reset ? issue_ack : '0;
    if (done && !final_done) begin
      chk("ack_left", 128'(ack_q.size()), 128'(0));
      chk("fire_left", 128'(fire_q.size()), 128'(0));
      chk("snap_left", 128'(snap_q.size()), 128'(0));
      final_done = 1'b1;
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
    rs_ready = rs_ready & ~last_ack;
  endtask

  task automatic load_entry(input int i, input int cls, input logic [2:0] tag,
                            input logic [31:0] a, input logic [31:0] b);
    rs_fu[2*i +: 2]       = 2'(cls);
    rs_rob_tag[3*i +: 3]  = tag;
    rs_v1[32*i +: 32]     = a;
    rs_v2[32*i +: 32]     = b;
    rs_ready[i]           = 1'b1;
  endtask

  task automatic exp_ack(input int c, input logic [4:0] v);
    ack_q.push_back('{c, v});
  endtask

  task automatic exp_fire(input int c, input int k, input logic [2:0] tag,
                          input logic [31:0] a, input logic [31:0] b);
    fire_q.push_back('{c, k, tag, a, b});
  endtask

  task automatic exp_snap(input int c, input logic [3:0] vld, input logic [4:0] ack,
                          input logic [3:0] mask, input logic [11:0] tag,
                          input logic [127:0] a, input logic [127:0] b);
    snap_q.push_back('{c, vld, ack, mask, tag, a, b});
  endtask

  int n;

  initial begin
    reset = 1'b1; squash = 1'b0; rs_ready = '0; rs_fu = '0; rs_rob_tag = '0;
    rs_v1 = '0; rs_v2 = '0; fu_ready = '0;
    #2 reset = 1'b0;
    // Reset state; a ready entry during reset must not be acked.
    load_entry(0, 0, 3'd1, 32'd1, 32'd1);
    @(posedge clock); #1;
    exp_snap(cyc, 4'b0000, 5'b00000, 4'b1111, '0, '0, '0);
    @(posedge clock); #1;
    rs_ready = '0;
    @(posedge clock); #3;
    reset = 1'b1;
    step();
    fu_ready = 4'b1111;

    // Three ALU entries held ready: acks 0,1,3 on consecutive cycles.
    n = cyc;
    load_entry(0, 0, 3'd1, 32'h10, 32'h11);
    load_entry(1, 0, 3'd2, 32'h20, 32'h21);
    load_entry(3, 0, 3'd3, 32'h30, 32'h31);
    exp_ack(n, 5'b00001); exp_ack(n+1, 5'b00010); exp_ack(n+2, 5'b01000);
    exp_fire(n+1, 0, 3'd1, 32'h10, 32'h11);
    exp_fire(n+2, 0, 3'd2, 32'h20, 32'h21);
    exp_fire(n+3, 0, 3'd3, 32'h30, 32'h31);
    repeat (4) step();

    // Pointer now sits at 4: entry 4 beats entry 2.
    n = cyc;
    load_entry(2, 0, 3'd6, 32'h60, 32'h61);
    load_entry(4, 0, 3'd7, 32'h70, 32'h71);
    exp_ack(n, 5'b10000); exp_ack(n+1, 5'b00100);
    exp_fire(n+1, 0, 3'd7, 32'h70, 32'h71);
    exp_fire(n+2, 0, 3'd6, 32'h60, 32'h61);
    repeat (3) step();

    // ALU stall for 3 cycles with entry 4 waiting.
    fu_ready = 4'b1110;
    n = cyc;
    load_entry(0, 0, 3'd2, 32'h100, 32'h200);
    exp_ack(n, 5'b00001);
    exp_fire(n+4, 0, 3'd2, 32'h100, 32'h200);
    step();
    load_entry(4, 0, 3'd3, 32'h300, 32'h400);
    for (int s = 1; s <= 3; s++) begin
      exp_snap(cyc, 4'b0001, 5'b00000, 4'b0001, {9'd0, 3'd2},
               {96'd0, 32'h100}, {96'd0, 32'h200});
      if (s < 3) step();
    end
    step();
    fu_ready = 4'b1111;
    exp_ack(cyc, 5'b10000);
    exp_fire(cyc+1, 0, 3'd3, 32'h300, 32'h400);
    repeat (2) step();

    // Single ALU op, one-cycle latency.
    n = cyc;
    load_entry(2, 0, 3'd5, 32'd7, 32'd9);
    exp_ack(n, 5'b00100);
    exp_fire(n+1, 0, 3'd5, 32'd7, 32'd9);
    repeat (2) step();

    // FP occupancy: second FP acked at N+4, valid/fires at N+5.
    n = cyc;
    load_entry(1, 3, 3'd1, 32'hA1, 32'hA2);
    load_entry(3, 3, 3'd2, 32'hB1, 32'hB2);
    exp_ack(n, 5'b00010); exp_fire(n+1, 3, 3'd1, 32'hA1, 32'hA2);
    exp_ack(n+4, 5'b01000); exp_fire(n+5, 3, 3'd2, 32'hB1, 32'hB2);
    repeat (10) step();

    // One ready entry per class: four acks in one cycle.
    n = cyc;
    load_entry(0, 0, 3'd1, 32'hC0, 32'hD0);
    load_entry(1, 1, 3'd2, 32'hC1, 32'hD1);
    load_entry(2, 2, 3'd3, 32'hC2, 32'hD2);
    load_entry(3, 3, 3'd4, 32'hC3, 32'hD3);
    exp_ack(n, 5'b01111);
    exp_fire(n+1, 0, 3'd1, 32'hC0, 32'hD0);
    exp_fire(n+1, 1, 3'd2, 32'hC1, 32'hD1);
    exp_fire(n+1, 2, 3'd3, 32'hC2, 32'hD2);
    exp_fire(n+1, 3, 3'd4, 32'hC3, 32'hD3);
    repeat (6) step();

    // Squash with all four registers full; the ALU fire in that cycle counts.
    fu_ready = 4'b0000;
    n = cyc;
    load_entry(0, 0, 3'd5, 32'hE0, 32'hF0);
    load_entry(1, 1, 3'd6, 32'hE1, 32'hF1);
    load_entry(2, 2, 3'd7, 32'hE2, 32'hF2);
    load_entry(3, 3, 3'd0, 32'hE3, 32'hF3);
    exp_ack(n, 5'b01111);
    step();
    load_entry(0, 0, 3'd1, 32'h55, 32'h66);
    squash = 1'b1;
    fu_ready = 4'b0001;
    exp_fire(cyc, 0, 3'd5, 32'hE0, 32'hF0);
    exp_snap(cyc, 4'b1111, 5'b00000, 4'b1111, {3'd0, 3'd7, 3'd6, 3'd5},
             {32'hE3, 32'hE2, 32'hE1, 32'hE0}, {32'hF3, 32'hF2, 32'hF1, 32'hF0});
    step();
    squash = 1'b0;
    fu_ready = 4'b1111;
    exp_snap(cyc, 4'b0000, 5'b00001, 4'b0000, '0, '0, '0);
    exp_ack(cyc, 5'b00001);
    exp_fire(cyc+1, 0, 3'd1, 32'h55, 32'h66);
    repeat (2) step();

    // Reset mid-stream clears outputs before the next clock edge.
    fu_ready = 4'b0000;
    load_entry(1, 1, 3'd2, 32'h77, 32'h88);
    exp_ack(cyc, 5'b00010);
    step();
    #2;
    reset = 1'b0;
    rs_ready = '0;
    exp_snap(cyc, 4'b0000, 5'b00000, 4'b1111, '0, '0, '0);
    @(posedge clock); #1;
    exp_snap(cyc, 4'b0000, 5'b00000, 4'b1111, '0, '0, '0);
    @(posedge clock); #3;
    reset = 1'b1;
    step();

    // Round-robin pointers restart at 0 after reset.
    fu_ready = 4'b1111;
    n = cyc;
    load_entry(0, 0, 3'd3, 32'h90, 32'h91);
    load_entry(1, 0, 3'd4, 32'h92, 32'h93);
    exp_ack(n, 5'b00001); exp_ack(n+1, 5'b00010);
    exp_fire(n+1, 0, 3'd3, 32'h90, 32'h91);
    exp_fire(n+2, 0, 3'd4, 32'h92, 32'h93);
    repeat (4) step();

    done = 1'b1;
    repeat (3) @(posedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
